// File: rtl/imem_pkg.sv
// imem_pkg: shared definitions for the instruction memory fetch port.
//   RV_NOP        - canonical RISC-V NOP (ADDI x0,x0,0), fill value and fault substitute
//   imem_state_t  - fill/run state of the memory controller
//   imem_addr_w() - word-index width for a given memory depth
package imem_pkg;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef enum logic {
    INIT,
    RUN
  } imem_state_t;

  function automatic int imem_addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/imem_sram.sv
// imem_sram: DEPTH x 32 synchronous memory, one write port and one read port.
// A read and a write to the same word on the same edge return the old contents.
// Ports:
//   clk    - clock, rising edge
//   we     - write enable
//   waddr  - word index to write
//   wdata  - word to write
//   re     - read enable; rdata only updates on an enabled read and holds otherwise
//   raddr  - word index to read
//   rdata  - registered read data
module imem_sram
  import imem_pkg::*;
#(
  parameter int  DEPTH = 256,
  localparam int AW    = imem_addr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  // NOTE: the array has no reset branch on purpose; clearing it is the job of
  // the fill sequence in the parent, which keeps this a plain RAM macro.
  logic [31:0] mem [DEPTH];

  // NOTE: non-blocking assignments give read-before-write for free: the read
  // samples mem before the write on the same edge lands.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_fetch_port.sv
// imem_fetch_port: synchronous instruction memory with a valid/ready fetch port.
// After reset it fills every word with NOP_WORD (DEPTH cycles), then serves one
// fetch per cycle with a single-entry response register and accepts loader
// writes.
// Optional build macro: IMEM_ADDR_CHECK_EN - flag misaligned or out-of-range
// fetches as faults returning NOP_WORD; when undefined, addresses wrap.
// Ports:
//   clk, rst         - clock (rising edge), synchronous active-high reset
//   fetch_req_valid  - fetch request present
//   fetch_req_ready  - request accepted when valid && ready
//   fetch_addr       - byte address of the instruction
//   fetch_rsp_valid  - response register holds an instruction
//   fetch_rsp_ready  - consumer takes the response
//   fetch_rsp_instr  - instruction word
//   fetch_rsp_addr   - byte address echoed from the request
//   fetch_rsp_fault  - misaligned/out-of-range fetch (always 0 without the macro)
//   load_we          - loader write strobe (ignored while filling)
//   load_addr        - loader word index
//   load_data        - loader word
//   init_done        - fill complete, fetches allowed
module imem_fetch_port
  import imem_pkg::*;
#(
  parameter int          XLEN     = 64,
  parameter int          DEPTH    = 256,
  parameter logic [31:0] NOP_WORD = RV_NOP,
  localparam int         AW       = imem_addr_w(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_req_valid,
  output logic            fetch_req_ready,
  input  logic [XLEN-1:0] fetch_addr,
  output logic            fetch_rsp_valid,
  input  logic            fetch_rsp_ready,
  output logic [31:0]     fetch_rsp_instr,
  output logic [XLEN-1:0] fetch_rsp_addr,
  output logic            fetch_rsp_fault,
  input  logic            load_we,
  input  logic [AW-1:0]   load_addr,
  input  logic [31:0]     load_data,
  output logic            init_done
);

  imem_state_t   state_q, state_d;
  logic [AW-1:0] fill_ptr_q, fill_ptr_d;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  logic          accept;
  logic          addr_fault;
  logic          rsp_from_mem_q;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      fill_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      fill_ptr_q <= fill_ptr_d;
    end
  end

  // ---------------- FSM: next state ----------------
  // NOTE: every output of an always_comb block gets a default first so no
  // path leaves it unassigned and infers a latch.
  always_comb begin
    state_d    = state_q;
    fill_ptr_d = fill_ptr_q;
    case (state_q)
      INIT: begin
        fill_ptr_d = fill_ptr_q + AW'(1);
        if (fill_ptr_q == AW'(DEPTH - 1)) state_d = RUN;
      end
      RUN: ;
    endcase
  end

  // ---------------- FSM: outputs / write-port mux ----------------
  always_comb begin
    init_done = 1'b0;
    mem_we    = load_we;
    mem_waddr = load_addr;
    mem_wdata = load_data;
    case (state_q)
      INIT: begin
        mem_we    = 1'b1;
        mem_waddr = fill_ptr_q;
        mem_wdata = NOP_WORD;
      end
      RUN: init_done = 1'b1;
    endcase
  end

  // ---------------- Address check ----------------
`ifdef IMEM_ADDR_CHECK_EN
  assign addr_fault = (fetch_addr[1:0] != 2'b00) || (fetch_addr[XLEN-1:AW+2] != '0);
`else
  // Byte-offset and high bits are don't-care; the index wraps modulo DEPTH*4.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{fetch_addr[XLEN-1:AW+2], fetch_addr[1:0]};
  assign addr_fault       = 1'b0;
`endif

  // ---------------- Handshake and response register ----------------
  // Ready depends combinationally on fetch_rsp_ready so a consumed response
  // can be replaced on the same edge without a bubble.
  assign fetch_req_ready = init_done && (!fetch_rsp_valid || fetch_rsp_ready);
  assign accept          = fetch_req_valid && fetch_req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_rsp_valid <= 1'b0;
      fetch_rsp_addr  <= '0;
      fetch_rsp_fault <= 1'b0;
      rsp_from_mem_q  <= 1'b0;
    end else if (accept) begin
      fetch_rsp_valid <= 1'b1;
      fetch_rsp_addr  <= fetch_addr;
      fetch_rsp_fault <= addr_fault;
      rsp_from_mem_q  <= !addr_fault;
    end else if (fetch_rsp_ready) begin
      fetch_rsp_valid <= 1'b0;
    end
  end

  // The RAM's read register holds between enabled reads, so the instruction
  // stays stable under backpressure; faults and reset show NOP_WORD instead.
  assign fetch_rsp_instr = rsp_from_mem_q ? mem_rdata : NOP_WORD;

  imem_sram #(
    .DEPTH(DEPTH)
  ) u_sram (
    .clk  (clk),
    .we   (mem_we),
    .waddr(mem_waddr),
    .wdata(mem_wdata),
    .re   (accept && !addr_fault),
    .raddr(fetch_addr[AW+1:2]),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_imem_fetch_port.sv
// Self-checking bench for imem_fetch_port: directed scenarios plus random
// traffic, compared against a word-array reference model of the memory and a
// single-entry response model.
module tb_imem_fetch_port;
  import imem_pkg::*;

  localparam int XLEN  = 64;
  localparam int DEPTH = 256;
  localparam int AW    = imem_addr_w(DEPTH);
`ifdef IMEM_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            fetch_req_valid;
  logic            fetch_req_ready;
  logic [XLEN-1:0] fetch_addr;
  logic            fetch_rsp_valid;
  logic            fetch_rsp_ready;
  logic [31:0]     fetch_rsp_instr;
  logic [XLEN-1:0] fetch_rsp_addr;
  logic            fetch_rsp_fault;
  logic            load_we;
  logic [AW-1:0]   load_addr;
  logic [31:0]     load_data;
  logic            init_done;

  imem_fetch_port #(
    .XLEN (XLEN),
    .DEPTH(DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_req_valid(fetch_req_valid),
    .fetch_req_ready(fetch_req_ready),
    .fetch_addr     (fetch_addr),
    .fetch_rsp_valid(fetch_rsp_valid),
    .fetch_rsp_ready(fetch_rsp_ready),
    .fetch_rsp_instr(fetch_rsp_instr),
    .fetch_rsp_addr (fetch_rsp_addr),
    .fetch_rsp_fault(fetch_rsp_fault),
    .load_we        (load_we),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .init_done      (init_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: memory contents and the one outstanding response.
  logic [31:0] m_mem [DEPTH];
  bit          m_init;
  bit          m_valid;
  logic [31:0] m_instr;
  logic [63:0] m_addr;
  bit          m_fault;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = RV_NOP;
    m_valid = 1'b0;
    m_instr = RV_NOP;
    m_addr  = '0;
    m_fault = 1'b0;
  endtask

  task automatic drive_idle();
    fetch_req_valid = 1'b0;
    fetch_addr      = '0;
    fetch_rsp_ready = 1'b1;
    load_we         = 1'b0;
    load_addr       = '0;
    load_data       = '0;
  endtask

  task automatic check_rsp(input string tag);
    check({tag, ".valid"}, 64'(fetch_rsp_valid), 64'(m_valid));
    check({tag, ".instr"}, 64'(fetch_rsp_instr), 64'(m_instr));
    check({tag, ".addr"},  fetch_rsp_addr,       m_addr);
    check({tag, ".fault"}, 64'(fetch_rsp_fault), 64'(m_fault));
  endtask

  // One clock cycle of traffic: drive at the falling edge, check the
  // combinational ready, advance the model, check the registered response.
  task automatic cycle(input string tag, input bit rv, input logic [63:0] a, input bit rr,
                       input bit lw, input int la, input logic [31:0] ld);
    bit exp_ready;
    bit flt;
    @(negedge clk);
    fetch_req_valid = rv;
    fetch_addr      = a;
    fetch_rsp_ready = rr;
    load_we         = lw;
    load_addr       = AW'(la);
    load_data       = ld;
    #1;
    exp_ready = m_init && (!m_valid || rr);
    check({tag, ".req_ready"}, 64'(fetch_req_ready), 64'(exp_ready));
    if (rv && exp_ready) begin
      flt     = ADDR_CHECK && ((a % 4) != 0 || (a / (DEPTH * 4)) != 0);
      m_valid = 1'b1;
      m_addr  = a;
      m_fault = flt;
      m_instr = flt ? RV_NOP : m_mem[(a / 4) % DEPTH];
    end else if (rr) begin
      m_valid = 1'b0;
    end
    if (lw && m_init) m_mem[la] = ld;
    @(posedge clk);
    #1;
    check_rsp(tag);
    check({tag, ".init_done"}, 64'(init_done), 64'(m_init));
  endtask

  // Reset with idle inputs, then run the fill while pushing fetches and
  // loader writes that must both be ignored.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    @(posedge clk);
    #1;
    m_init = 1'b0;
    model_reset();
    check("rst.req_ready", 64'(fetch_req_ready), 64'(0));
    check("rst.init_done", 64'(init_done), 64'(0));
    check_rsp("rst");
    @(negedge clk);
    rst             = 1'b0;
    fetch_req_valid = 1'b1;
    fetch_addr      = '0;
    load_we         = 1'b1;
    load_addr       = '0;
    load_data       = 32'hFFFF_FFFF;
    for (int i = 1; i <= DEPTH; i++) begin
      @(posedge clk);
      #1;
      if (i == 1 || i == DEPTH / 2 || i == DEPTH - 1 || i == DEPTH)
        check($sformatf("fill.init_done@%0d", i), 64'(init_done), 64'(i == DEPTH));
      if (i < DEPTH) check("fill.req_ready", 64'(fetch_req_ready), 64'(0));
    end
    check("fill.rsp_valid", 64'(fetch_rsp_valid), 64'(0));
    m_init = 1'b1;
    @(negedge clk);
    drive_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit          rv, rr, lw;
    logic [63:0] a;
    rst    = 1'b1;
    m_init = 1'b0;
    model_reset();
    drive_idle();

    do_reset();

    // Freshly filled memory returns NOP at both ends.
    cycle("fetch0",   1, 64'h0, 1, 0, 0, '0);
    cycle("fetchtop", 1, 64'((DEPTH - 1) * 4), 1, 0, 0, '0);
    cycle("idle0",    0, 64'h0, 1, 0, 0, '0);

    // Load then fetch.
    cycle("load0",  0, 64'h0, 1, 1, 0, 32'h0080_8567);
    cycle("fetchl", 1, 64'h0, 1, 0, 0, '0);
    check("fetchl.instr_const", 64'(fetch_rsp_instr), 64'h0080_8567);
    cycle("idle1",  0, 64'h0, 1, 0, 0, '0);

    // Back-to-back fetches, no bubbles.
    cycle("b2b0", 1, 64'h0, 1, 1, 1, 32'h1111_1111);
    cycle("b2b1", 1, 64'h4, 1, 0, 0, '0);
    cycle("b2b2", 1, 64'h8, 1, 0, 0, '0);
    cycle("b2b3", 0, 64'h0, 1, 0, 0, '0);

    // Backpressure: held response, next request waits then goes immediately.
    cycle("bp0", 1, 64'h0, 1, 0, 0, '0);
    for (int i = 0; i < 3; i++) cycle($sformatf("bp_hold%0d", i), 1, 64'h4, 0, 0, 0, '0);
    cycle("bp_release", 1, 64'h4, 1, 0, 0, '0);
    cycle("bp_idle",    0, 64'h0, 1, 0, 0, '0);

    // Same-cycle load and fetch of one word: old value first, new value next.
    cycle("rbw0", 1, 64'h8, 1, 1, 2, 32'hDEAD_BEEF);
    check("rbw0.old", 64'(fetch_rsp_instr), 64'(RV_NOP));
    cycle("rbw1", 1, 64'h8, 1, 0, 0, '0);
    check("rbw1.new", 64'(fetch_rsp_instr), 64'hDEAD_BEEF);

    // Misaligned and out-of-range addresses.
    cycle("odd",   1, 64'h2,   1, 0, 0, '0);
    cycle("range", 1, 64'h400, 1, 0, 0, '0);
    cycle("high",  1, 64'h0000_0100_0000_0004, 1, 0, 0, '0);
    cycle("idle2", 0, 64'h0,   1, 0, 0, '0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 3) != 0);
      lw = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0, 1:    a = 64'($urandom_range(0, DEPTH - 1)) * 4;
        2:       a = 64'($urandom_range(0, DEPTH * 4 - 1));
        default: a = {32'($urandom), 32'($urandom)};
      endcase
      cycle("rand", rv, a, rr, lw, int'($urandom_range(0, DEPTH - 1)), 32'($urandom));
    end

    // Reset mid-stream with a response held, and reset again mid-fill.
    cycle("pre_rst_load", 0, 64'h0, 1, 1, 5, 32'hCAFE_F00D);
    cycle("pre_rst_hold", 1, 64'h14, 0, 0, 0, '0);
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    @(posedge clk);
    #1;
    check("midrst.rsp_valid", 64'(fetch_rsp_valid), 64'(0));
    check("midrst.init_done", 64'(init_done), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) @(posedge clk);
    #1;
    check("midfill.init_done", 64'(init_done), 64'(0));
    do_reset();
    cycle("post_rst5", 1, 64'h14, 1, 0, 0, '0);
    check("post_rst5.nop", 64'(fetch_rsp_instr), 64'(RV_NOP));
    cycle("post_rst0", 1, 64'h0, 1, 0, 0, '0);
    cycle("post_idle", 0, 64'h0, 1, 0, 0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_fetch_port.md
# imem_fetch_port

Parametrised, synchronous instruction memory with a valid/ready fetch interface, replacing the earlier combinational, simulation-preloaded instruction ROM. It sits between the PC/fetch stage and the decode stage. After reset it self-initialises every word to NOP, accepts program writes through a loader port, and returns one instruction per cycle with backpressure support.

## Interface
- XLEN, 64, width of fetch and response addresses
- DEPTH, 256, number of 32-bit words; power of two, at least 4
- NOP_WORD, 32'h0000_0013, fill value and fault substitute (ADDI x0,x0,0)
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous reset, active-high
- fetch_req_valid  in  1  fetch request present
- fetch_req_ready  out  1  request accepted on a cycle where valid and ready are both high
- fetch_addr  in  XLEN  byte address of the instruction
- fetch_rsp_valid  out  1  response holds an instruction
- fetch_rsp_ready  in  1  consumer takes the response
- fetch_rsp_instr  out  32  instruction word
- fetch_rsp_addr  out  XLEN  byte address echoed from the request
- fetch_rsp_fault  out  1  misaligned or out-of-range fetch (IMEM_ADDR_CHECK_EN only)
- load_we  in  1  loader write strobe
- load_addr  in  log2(DEPTH)  word index to write
- load_data  in  32  word to write
- init_done  out  1  fill complete; fetches are allowed

## Operation
- Two-state FSM: INIT and RUN. The `rst` input forces INIT with fill pointer 0.
- INIT: write NOP_WORD to word[ptr] each cycle and increment ptr. After writing ptr = DEPTH-1, go to RUN. The `load_we` input is ignored. `fetch_req_ready` is 0.
- RUN: stay until `rst`. `init_done` is 1.
- Word index is `fetch_addr[log2(DEPTH)+1:2]`.
- Acceptance rule: `fetch_req_ready = init_done && (!fetch_rsp_valid || fetch_rsp_ready)`.
- On acceptance, the memory is read and the result is registered into the response (instr, addr, fault). `fetch_rsp_valid` is set.
- Without a new acceptance, a consumed response clears `fetch_rsp_valid`.
- An unconsumed response holds all response fields stable.
- Loader writes in RUN take effect at the clock edge.
- A fetch to the same word in the same cycle returns the old data (read-before-write).
- Loader writes never stall fetches.

## Timing
- Reset values:
  - `fetch_req_ready` = 0
  - `fetch_rsp_valid` = 0
  - `fetch_rsp_instr` = NOP_WORD
  - `fetch_rsp_addr` = 0
  - `fetch_rsp_fault` = 0
  - `init_done` = 0
- Init duration: exactly DEPTH cycles. `init_done` rises on the DEPTH-th rising edge after the first edge with `rst` low.
- Fetch latency: 1 cycle, from the accepting edge to `fetch_rsp_valid` high.
- Throughput: 1 fetch per cycle while `fetch_rsp_ready` is held high.
- Backpressure: with `fetch_rsp_ready` low, at most one response is outstanding and `fetch_req_ready` drops in the same cycle (combinational from `fetch_rsp_ready`).
- Reset mid-operation, in either state:
  - the pending response is discarded
  - the fill restarts at word 0
  - prior loader contents are overwritten with NOP

## Configuration
- Macro: `IMEM_ADDR_CHECK_EN`.
- Defined: `fetch_rsp_fault` = 1 when `fetch_addr[1:0]` != 0 or any bit above `log2(DEPTH)+1` is set. On a fault, `fetch_rsp_instr` = NOP_WORD, memory is not read, and the handshake is unchanged.
- Undefined: `fetch_rsp_fault` is tied to 0. Low and high address bits are ignored, so addresses wrap modulo DEPTH*4.

## Structure
- Package `imem_pkg` holds:
  - `RV_NOP` constant
  - `imem_state_t` enum (INIT, RUN)
  - `imem_addr_w(depth)` helper returning log2(depth)
- Sub-module `imem_sram`: DEPTH x 32 array with one synchronous write port and one synchronous read port, read-before-write.
- The top level muxes the write port between the fill pointer (INIT) and the loader (RUN).

## Test plan
- Reset, DEPTH=256 -> `init_done` low for 256 cycles, then high. Fetches of addresses 0x0, 0x3FC return 0x00000013 with no fault.
- Load word 0 = 0x00808567, then fetch 0x0 -> one cycle later instr = 0x00808567, addr = 0x0, fault = 0.
- Back-to-back fetches of 0x0, 0x4, 0x8 with `fetch_rsp_ready` held high -> three consecutive valid responses, in order, with no bubbles.
- Hold `fetch_rsp_ready` low for 3 cycles after the first response -> `fetch_req_ready` = 0 and the response is stable for 3 cycles. The next request is accepted in the cycle `fetch_rsp_ready` returns high.
- Same-cycle load of word 2 = 0xDEADBEEF and fetch of 0x8 -> returns the old value 0x00000013. The next fetch of 0x8 returns 0xDEADBEEF.
- With `IMEM_ADDR_CHECK_EN`: fetches of 0x2 and 0x400 -> fault = 1, instr = 0x00000013. Without it: 0x400 returns word 0 with fault = 0. Assert `rst` mid-stream -> `fetch_rsp_valid` is 0 on the next edge and the fill restarts.
